tv80_alu_wide: RTL and testbench



---
 rtl/tv80_alu_pkg.sv | 38 +++
 rtl/tv80_alu_muldiv_iter.sv | 74 +++++++
 rtl/tv80_alu_wide.sv | 178 +++++++++++++++++
 tb/tb_tv80_alu_wide.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tv80_alu_pkg.sv
// Shared definitions for the wide TV80 ALU: opcodes, flag bit positions, FSM states.
// The iterative MUL/DIV unit is built only when TV80_ALU_MULDIV_EN is defined.
package tv80_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_XOR = 4'd5,
        OP_OR  = 4'd6,
        OP_CP  = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_C  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_X  = 3;
    localparam int FLAG_H  = 4;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    // Z80 P flag: set when the number of ones is even (zero-extended input).
    function automatic logic parity_even(input logic [31:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/tv80_alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Instantiated by tv80_alu_wide only when TV80_ALU_MULDIV_EN is defined.
module tv80_alu_muldiv_iter #(
    parameter int W       = 8,
    parameter int MD_CNTW = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         mode_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi,
    output logic         is_div
);
    import tv80_alu_pkg::*;

    localparam logic [MD_CNTW-1:0] CNT_LAST = MD_CNTW'(W - 1);

    logic [2*W-1:0]     acc_reg;
    logic [W-1:0]       opb_reg;
    logic [MD_CNTW-1:0] cnt_reg;
    logic               run_reg;
    logic               div_reg;

    logic [W:0]         add_sum;
    logic [W:0]         rem_sh;
    logic [W:0]         trial;
    logic [2*W-1:0]     acc_step;

    // Accumulator is {high, low}: product-high/multiplier for MUL, remainder/quotient for DIV.
    always_comb begin
        add_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        rem_sh   = {acc_reg[2*W-1:W], acc_reg[W-1]};
        trial    = rem_sh - {1'b0, opb_reg};
        acc_step = {add_sum, acc_reg[W-1:1]};
        if (div_reg) begin
            if (trial[W])
                acc_step = {rem_sh[W-1:0], acc_reg[W-2:0], 1'b0};
            else
                acc_step = {trial[W-1:0], acc_reg[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
            opb_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
            div_reg <= 1'b0;
        end else if (start) begin
            acc_reg <= {{W{1'b0}}, a};
            opb_reg <= b;
            cnt_reg <= '0;
            run_reg <= 1'b1;
            div_reg <= mode_div;
        end else if (run_reg) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (done)
                run_reg <= 1'b0;
        end
    end

    // Results are the value of the final step, so the caller captures them on the done edge.
    assign done   = run_reg && (cnt_reg == CNT_LAST);
    assign res_lo = acc_step[W-1:0];
    assign res_hi = acc_step[2*W-1:W];
    assign is_div = div_reg;

endmodule

// File: rtl/tv80_alu_wide.sv
// W-bit TV80-style ALU with valid/ready request port and registered result/flags.
// Define TV80_ALU_MULDIV_EN to build iterative MUL/DIV; otherwise opcodes 8/9 act as NOP.
module tv80_alu_wide
    import tv80_alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int MD_CNTW = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [7:0]   f_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_q,
    output logic [W-1:0] res_q_hi,
    output logic [7:0]   f_out,
    output logic         busy
);

    alu_state_e   state_reg;
    alu_state_e   state_next;
    logic [W-1:0] res_q_reg;
    logic [W-1:0] res_hi_reg;
    logic [7:0]   f_reg;

    alu_op_e      op_e;
    logic         accept;
    logic         is_sub;
    logic         cin;
    logic [W-1:0] b_x;
    logic [W:0]   sum_full;
    logic [W-1:0] arith_q;
    logic         arith_c;
    logic         arith_h;
    logic         arith_v;
    logic [W-1:0] logic_q;

    logic [W-1:0] sc_q;
    logic [W-1:0] sc_hi;
    logic [7:0]   sc_f;

    logic         md_start;
    logic         md_done;
    logic [W-1:0] md_lo;
    logic [W-1:0] md_hi;
    logic         md_div;
    logic [7:0]   md_f;

    assign op_e   = alu_op_e'(op);
    assign accept = op_valid && op_ready;

    // Subtraction is a + ~b + ~borrow; carries are inverted afterwards to give borrows.
    assign is_sub   = (op_e == OP_SUB) || (op_e == OP_SBC) || (op_e == OP_CP);
    assign cin      = (op_e == OP_ADC) ? f_in[FLAG_C] :
                      (op_e == OP_SBC) ? ~f_in[FLAG_C] : is_sub;
    assign b_x      = is_sub ? ~op_b : op_b;
    assign sum_full = {1'b0, op_a} + {1'b0, b_x} + {{W{1'b0}}, cin};
    assign arith_q  = sum_full[W-1:0];
    assign arith_c  = sum_full[W] ^ is_sub;
    // Carry into a bit is recovered as sum ^ a ^ b at that bit.
    assign arith_h  = (sum_full[4] ^ op_a[4] ^ b_x[4]) ^ is_sub;
    assign arith_v  = sum_full[W] ^ (sum_full[W-1] ^ op_a[W-1] ^ b_x[W-1]);

    always_comb begin
        logic_q = op_a | op_b;
        if (op_e == OP_AND)
            logic_q = op_a & op_b;
        else if (op_e == OP_XOR)
            logic_q = op_a ^ op_b;
    end

    always_comb begin
        sc_q  = op_a;
        sc_hi = '0;
        sc_f  = f_in;
        case (op_e)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                sc_q = arith_q;
                sc_f = {arith_q[W-1], ~|arith_q, arith_q[5], arith_h,
                        arith_q[3], arith_v, is_sub, arith_c};
            end
            OP_CP: begin
                sc_f = {arith_q[W-1], ~|arith_q, op_b[5], arith_h,
                        op_b[3], arith_v, 1'b1, arith_c};
            end
            OP_AND, OP_XOR, OP_OR: begin
                sc_q = logic_q;
                sc_f = {logic_q[W-1], ~|logic_q, logic_q[5], op_e == OP_AND,
                        logic_q[3], parity_even(32'(logic_q)), 1'b0, 1'b0};
            end
`ifdef TV80_ALU_MULDIV_EN
            // Only divide-by-zero takes this path; non-zero divisors go to the iterative unit.
            OP_DIV: begin
                sc_q  = '1;
                sc_hi = op_a;
                sc_f  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            end
`endif
            default: ;
        endcase
    end

`ifdef TV80_ALU_MULDIV_EN
    assign md_start = accept && ((op_e == OP_MUL) || ((op_e == OP_DIV) && (op_b != '0)));

    tv80_alu_muldiv_iter #(
        .W       (W),
        .MD_CNTW (MD_CNTW)
    ) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (md_start),
        .mode_div (op_e == OP_DIV),
        .a        (op_a),
        .b        (op_b),
        .done     (md_done),
        .res_lo   (md_lo),
        .res_hi   (md_hi),
        .is_div   (md_div)
    );
`else
    assign md_start = 1'b0;
    assign md_done  = 1'b0;
    assign md_lo    = '0;
    assign md_hi    = '0;
    assign md_div   = 1'b0;
`endif

    always_comb begin
        md_f = {md_hi[W-1], ~|{md_hi, md_lo}, md_lo[5], 1'b0,
                md_lo[3], |md_hi, 1'b0, |md_hi};
        if (md_div)
            md_f = {md_lo[W-1], ~|md_lo, md_lo[5], 1'b0, md_lo[3], 1'b0, 1'b0, 1'b0};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = md_start ? BUSY : DONE;
            BUSY:    if (md_done) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            res_q_reg  <= '0;
            res_hi_reg <= '0;
            f_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && !md_start) begin
                res_q_reg  <= sc_q;
                res_hi_reg <= sc_hi;
                f_reg      <= sc_f;
            end else if (md_done) begin
                res_q_reg  <= md_lo;
                res_hi_reg <= md_hi;
                f_reg      <= md_f;
            end
        end
    end

    assign op_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == BUSY);
    assign res_valid = (state_reg == DONE);
    assign res_q     = res_q_reg;
    assign res_q_hi  = res_hi_reg;
    assign f_out     = f_reg;

endmodule

// File: tb/tb_tv80_alu_wide.sv
// Bench for tv80_alu_wide at W=8 and W=16 against an arithmetic reference model.
// Expectations follow TV80_ALU_MULDIV_EN: when undefined, opcodes 8/9 are expected to act as NOP.
module tb_tv80_alu_wide;

`ifdef TV80_ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel16;
    logic        op_valid;
    logic        res_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  fin;

    logic        rdy8, rv8, busy8;
    logic [7:0]  q8, hi8, f8;
    logic        rdy16, rv16, busy16;
    logic [15:0] q16, hi16;
    logic [7:0]  f16;

    int compared   = 0;
    int mismatched = 0;

    tv80_alu_wide #(.W(8), .MD_CNTW(6)) dut8 (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid && !sel16), .op_ready(rdy8),
        .op(op), .op_a(a[7:0]), .op_b(b[7:0]), .f_in(fin),
        .res_valid(rv8), .res_ready(res_ready), .res_q(q8), .res_q_hi(hi8),
        .f_out(f8), .busy(busy8)
    );

    tv80_alu_wide #(.W(16), .MD_CNTW(6)) dut16 (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid && sel16), .op_ready(rdy16),
        .op(op), .op_a(a), .op_b(b), .f_in(fin),
        .res_valid(rv16), .res_ready(res_ready), .res_q(q16), .res_q_hi(hi16),
        .f_out(f16), .busy(busy16)
    );

    logic        rdy_m, rv_m, busy_m;
    logic [15:0] q_m, hi_m;
    logic [7:0]  f_m;
    assign rdy_m  = sel16 ? rdy16  : rdy8;
    assign rv_m   = sel16 ? rv16   : rv8;
    assign busy_m = sel16 ? busy16 : busy8;
    assign q_m    = sel16 ? q16    : {8'h00, q8};
    assign hi_m   = sel16 ? hi16   : {8'h00, hi8};
    assign f_m    = sel16 ? f16    : f8;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bitof(input longint v, input int i);
        return ((v >> i) & 64'sd1) != 0;
    endfunction

    // Reference: flags from plain integer arithmetic (unsigned and signed ranges).
    task automatic model(input int w, input int opc, input logic [15:0] av, input logic [15:0] bv,
                         input logic [7:0] fv, output logic [63:0] q, output logic [63:0] hi,
                         output logic [7:0] f, output int lat);
        longint ua, ub, mask, smax, smin, sa, sb, full, sv, res, p;
        int eo, ci;
        bit s, z, y, h, x, pv, n, c;
        ua = longint'(av); ub = longint'(bv);
        mask = (longint'(1) << w) - 1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -smax - 1;
        sa = (ua > smax) ? ua - (mask + 1) : ua;
        sb = (ub > smax) ? ub - (mask + 1) : ub;
        eo = opc;
        if (!MD_EN && (opc == 8 || opc == 9)) eo = 15;
        {s, z, y, h, x, pv, n, c} = 8'h00;
        q = 0; hi = 0; lat = 1; res = 0;
        case (eo)
            0, 1, 2, 3, 7: begin
                ci = ((eo == 1 || eo == 3) && fv[0]) ? 1 : 0;
                if (eo <= 1) begin
                    full = ua + ub + ci; sv = sa + sb + ci;
                    h = ((ua & 15) + (ub & 15) + ci) > 15; c = full > mask; n = 0;
                end else begin
                    full = ua - ub - ci; sv = sa - sb - ci;
                    h = ((ua & 15) - (ub & 15) - ci) < 0; c = full < 0; n = 1;
                end
                res = full & mask;
                pv = (sv > smax) || (sv < smin);
                s = bitof(res, w - 1); z = (res == 0);
                q = (eo == 7) ? ua : res;
                y = bitof((eo == 7) ? ub : res, 5);
                x = bitof((eo == 7) ? ub : res, 3);
            end
            4, 5, 6: begin
                res = (eo == 4) ? (ua & ub) : (eo == 5) ? (ua ^ ub) : (ua | ub);
                q = res; s = bitof(res, w - 1); z = (res == 0);
                y = bitof(res, 5); x = bitof(res, 3); h = (eo == 4);
                pv = ($countones(res) % 2) == 0;
            end
            8: begin
                p = ua * ub;
                q = p & mask; hi = p >> w;
                s = bitof(p, 2 * w - 1); z = (p == 0);
                c = (hi != 0); pv = c;
                y = bitof(p, 5); x = bitof(p, 3);
                lat = w + 1;
            end
            9: begin
                if (ub == 0) begin
                    res = mask; hi = ua; c = 1;
                end else begin
                    res = ua / ub; hi = ua % ub; lat = w + 1;
                end
                q = res; s = bitof(res, w - 1); z = (res == 0);
                y = bitof(res, 5); x = bitof(res, 3);
            end
            default: begin
                q = ua;
            end
        endcase
        f = (eo >= 10) ? fv : {s, z, y, h, x, pv, n, c};
    endtask

    task automatic do_op(input bit w16, input int opc, input logic [15:0] av_in,
                         input logic [15:0] bv_in, input logic [7:0] fv, input int hold,
                         input string tag);
        logic [63:0] eq, eh;
        logic [7:0]  ef;
        logic [15:0] av, bv;
        int elat, lat;
        av = av_in; bv = bv_in;
        if (!w16) begin av[15:8] = 8'h00; bv[15:8] = 8'h00; end
        model(w16 ? 16 : 8, opc, av, bv, fv, eq, eh, ef, elat);
        @(negedge clk);
        sel16 = w16; op = opc[3:0]; a = av; b = bv; fin = fv; op_valid = 1'b1;
        check({tag, ".op_ready"}, 64'(rdy_m), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
        lat = 1;
        while (rv_m !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op=%0d w=%0d a=%h b=%h fin=%h -> q=%h hi=%h f=%h lat=%0d (exp q=%h hi=%h f=%h lat=%0d)",
                 opc, w16 ? 16 : 8, av, bv, fv, q_m, hi_m, f_m, lat, eq[15:0], eh[15:0], ef, elat);
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".res_q"}, 64'(q_m), eq);
        check({tag, ".res_q_hi"}, 64'(hi_m), eh);
        check({tag, ".f_out"}, 64'(f_m), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 64'(rv_m), 64'd1);
            check({tag, ".hold_ready"}, 64'(rdy_m), 64'd0);
            check({tag, ".hold_q"}, 64'(q_m), eq);
            check({tag, ".hold_f"}, 64'(f_m), 64'(ef));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, ".idle_ready"}, 64'(rdy_m), 64'd1);
        check({tag, ".idle_valid"}, 64'(rv_m), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; sel16 = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        op = 4'd0; a = 16'h0; b = 16'h0; fin = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst8.valid", 64'(rv8), 64'd0);
        check("rst8.q", 64'(q8), 64'd0);
        check("rst8.hi", 64'(hi8), 64'd0);
        check("rst8.f", 64'(f8), 64'd0);
        check("rst8.ready", 64'(rdy8), 64'd1);
        check("rst8.busy", 64'(busy8), 64'd0);
        check("rst16.valid", 64'(rv16), 64'd0);
        check("rst16.q", 64'(q16), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op(1'b0, 0, 16'h7F, 16'h01, 8'h00, 0, "add_7f_01");
        do_op(1'b1, 3, 16'h0000, 16'h0000, 8'h01, 0, "sbc16_0_0_c");
        do_op(1'b0, 8, 16'hFF, 16'hFF, 8'h00, 0, "mul_ff_ff");
        do_op(1'b0, 9, 16'd200, 16'd7, 8'h00, 0, "div_200_7");
        do_op(1'b0, 9, 16'd5, 16'd0, 8'h00, 0, "div_5_0");
        do_op(1'b0, 7, 16'h30, 16'h28, 8'h00, 0, "cp_30_28");
        do_op(1'b0, 4, 16'hF0, 16'h3C, 8'h00, 0, "and_f0_3c");
        do_op(1'b0, 1, 16'hFF, 16'h00, 8'h01, 0, "adc_ff_00_c");
        do_op(1'b0, 12, 16'h5A, 16'h11, 8'hC3, 0, "nop_5a");
        do_op(1'b0, 8, 16'h9A, 16'h47, 8'h00, 5, "hold_mul");
        do_op(1'b0, 2, 16'h10, 16'h20, 8'h00, 5, "hold_sub");

        // Reset in the middle of a MUL (or a held NOP result when MUL/DIV is not built).
        @(negedge clk);
        sel16 = 1'b0; op = 4'd8; a = 16'h00A5; b = 16'h003C; fin = 8'hFF; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midmul.busy", 64'(busy8), 64'(MD_EN));
        check("midmul.valid", 64'(rv8), 64'(!MD_EN));
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst.valid", 64'(rv8), 64'd0);
        check("midrst.q", 64'(q8), 64'd0);
        check("midrst.hi", 64'(hi8), 64'd0);
        check("midrst.f", 64'(f8), 64'd0);
        check("midrst.busy", 64'(busy8), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(1'b0, 0, 16'h3C, 16'h4A, 8'h00, 0, "add_after_rst");

        for (int i = 0; i < 40; i++) begin
            int ro;
            logic [15:0] rb;
            ro = $urandom_range(0, 15);
            rb = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            do_op(1'b0, ro, 16'($urandom), rb, 8'($urandom), 0, "rand8");
        end
        for (int i = 0; i < 25; i++) begin
            int ro;
            logic [15:0] rb;
            ro = $urandom_range(0, 15);
            rb = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            do_op(1'b1, ro, 16'($urandom), rb, 8'($urandom), 0, "rand16");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
